// File: rtl/fp64_to_int_conv.sv
// fp64_to_int_conv: binary64 -> signed OUT_W-bit integer, selectable rounding, saturating with flags.
// out_valid rises on the 3rd edge counting the accepting one; result held until out_ready, in_ready low while busy.
module fp64_to_int_conv #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      a,
    input  logic [1:0]       rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             invalid,
    output logic             inexact
);

    localparam int MW = OUT_W + 1;
    // Fixed-point window: binary point at bit 64, integer part in the top MW bits.
    localparam int SW = OUT_W + 65;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam logic [MW-1:0]    POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
    localparam logic [MW-1:0]    NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_RES = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_RES = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [12:0] OUT_W_S = 13'(OUT_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q,   state_d;
    logic [63:0]       a_q,       a_d;
    logic [1:0]        rm_q,      rm_d;
    logic              sign_q,    sign_d;
    logic [MW-1:0]     mag_q,     mag_d;
    logic              g_q,       g_d;
    logic              s_q,       s_d;
    logic              nan_q,     nan_d;
    logic              big_q,     big_d;
    logic [OUT_W-1:0]  result_q,  result_d;
    logic              invalid_q, invalid_d;
    logic              inexact_q, inexact_d;

    // Field decode and alignment of the latched operand
    logic [10:0]        exp_f;
    logic [51:0]        man;
    logic [52:0]        sig;
    logic signed [12:0] exp_unb;
    logic [6:0]         sh_amt;
    logic [SW-1:0]      shifted;

    always_comb begin
        exp_f   = a_q[62:52];
        man     = a_q[51:0];
        sig     = {(exp_f != 11'd0), man};
        exp_unb = $signed({2'b00, exp_f}) - 13'sd1023;
        sh_amt  = exp_unb[6:0] + 7'd12;
        shifted = SW'(sig) << sh_amt;
    end

    // Rounding of the aligned magnitude
    logic          inc;
    logic [MW-1:0] mag_r;
    logic [OUT_W-1:0] mag_lo;

    always_comb begin
        inc = 1'b0;
        case (rm_q)
            RM_RNE: inc = g_q & (s_q | mag_q[0]);
            RM_RTZ: inc = 1'b0;
            RM_RUP: inc = (g_q | s_q) & ~sign_q;
            RM_RDN: inc = (g_q | s_q) & sign_q;
            default: inc = 1'b0;
        endcase
        mag_r  = mag_q + {{(MW-1){1'b0}}, inc};
        mag_lo = mag_r[OUT_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        rm_d      = rm_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        g_d       = g_q;
        s_d       = s_q;
        nan_d     = nan_q;
        big_d     = big_q;
        result_d  = result_q;
        invalid_d = invalid_q;
        inexact_d = inexact_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    rm_d    = rm;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                sign_d = a_q[63];
                nan_d  = 1'b0;
                big_d  = 1'b0;
                mag_d  = '0;
                g_d    = 1'b0;
                s_d    = 1'b0;
                if (exp_f == 11'h7FF) begin
                    nan_d = (man != 52'd0);
                    big_d = (man == 52'd0);
                end else if (exp_unb < 13'sd0) begin
                    // Pure fraction: only exponent -1 puts the leading one in the guard position
                    g_d = (exp_unb == -13'sd1);
                    s_d = (exp_unb == -13'sd1) ? (man != 52'd0) : (sig != 53'd0);
                end else if (exp_unb >= OUT_W_S) begin
                    big_d = 1'b1;
                end else begin
                    mag_d = shifted[SW-1:64];
                    g_d   = shifted[63];
                    s_d   = |shifted[62:0];
                end
                state_d = ROUND;
            end
            ROUND: begin
                invalid_d = 1'b0;
                inexact_d = 1'b0;
                if (nan_q) begin
                    result_d  = MAX_RES;
                    invalid_d = 1'b1;
                end else if (big_q) begin
                    result_d  = sign_q ? MIN_RES : MAX_RES;
                    invalid_d = 1'b1;
                end else if (sign_q && (mag_r > NEG_LIM)) begin
                    result_d  = MIN_RES;
                    invalid_d = 1'b1;
                end else if (!sign_q && (mag_r > POS_LIM)) begin
                    result_d  = MAX_RES;
                    invalid_d = 1'b1;
                end else begin
                    // Negating a zero magnitude yields 0, so -0 never becomes all-ones
                    result_d  = sign_q ? (-mag_lo) : mag_lo;
                    inexact_d = g_q | s_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            rm_q      <= '0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            g_q       <= 1'b0;
            s_q       <= 1'b0;
            nan_q     <= 1'b0;
            big_q     <= 1'b0;
            result_q  <= '0;
            invalid_q <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            rm_q      <= rm_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            g_q       <= g_d;
            s_q       <= s_d;
            nan_q     <= nan_d;
            big_q     <= big_d;
            result_q  <= result_d;
            invalid_q <= invalid_d;
            inexact_q <= inexact_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp64_to_int_conv.sv
// Bench for fp64_to_int_conv: vector table, backpressure, mid-conversion reset, random integer round trip.
module tb_fp64_to_int_conv;

    localparam int OUT_W = 32;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RUP = 2'b10;
    localparam logic [1:0] RDN = 2'b11;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      a;
    logic [1:0]       rm;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] result;
    logic             invalid;
    logic             inexact;

    always #5 clk = ~clk;

    fp64_to_int_conv #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    typedef struct {
        logic [63:0] a;
        logic [1:0]  rm;
        logic [31:0] res;
        logic        inv;
        logic        inx;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        inx;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake one operand; returns #1 after the accepting edge
    task automatic drive(input logic [63:0] va, input logic [1:0] vrm);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        a        = va;
        rm       = vrm;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = ~va;
        rm       = ~vrm;
    endtask

    task automatic send(input logic [63:0] va, input logic [1:0] vrm, input exp_t e);
        sb.push_back(e);
        drive(va, vrm);
    endtask

    // Waits for out_valid, compares against the scoreboard head; edges counts the accepting edge as 1
    task automatic collect(input string tag, input bit consume, output int edges);
        exp_t e;
        edges = 1;
        while (!out_valid && edges < 30) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!out_valid) begin
            check({tag, "_out_valid_timeout"}, 64'(out_valid), 64'd1);
            return;
        end
        if (sb.size() == 0) begin
            check({tag, "_unexpected_output"}, 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        last_exp = e;
        check({tag, "_result"},  64'(result),  64'(e.res));
        check({tag, "_invalid"}, 64'(invalid), 64'(e.inv));
        check({tag, "_inexact"}, 64'(inexact), 64'(e.inx));
        if (consume) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic watch_no_output(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        vec_t tbl [0:24];
        int   edges;
        exp_t e;

        tbl[0]  = '{64'h3FF8000000000000, RNE, 32'h00000002, 1'b0, 1'b1};
        tbl[1]  = '{64'h4004000000000000, RNE, 32'h00000002, 1'b0, 1'b1};
        tbl[2]  = '{64'hC004000000000000, RTZ, 32'hFFFFFFFE, 1'b0, 1'b1};
        tbl[3]  = '{64'hBFE8000000000000, RDN, 32'hFFFFFFFF, 1'b0, 1'b1};
        tbl[4]  = '{64'hC1E0000000000000, RNE, 32'h80000000, 1'b0, 1'b0};
        tbl[5]  = '{64'h41E0000000000000, RNE, 32'h7FFFFFFF, 1'b1, 1'b0};
        tbl[6]  = '{64'h41DFFFFFFFC00000, RNE, 32'h7FFFFFFF, 1'b0, 1'b0};
        tbl[7]  = '{64'h7FF8000000000000, RNE, 32'h7FFFFFFF, 1'b1, 1'b0};
        tbl[8]  = '{64'hFFF0000000000000, RTZ, 32'h80000000, 1'b1, 1'b0};
        tbl[9]  = '{64'h0000000000000001, RUP, 32'h00000001, 1'b0, 1'b1};
        tbl[10] = '{64'h8000000000000000, RNE, 32'h00000000, 1'b0, 1'b0};
        tbl[11] = '{64'h8000000000000001, RDN, 32'hFFFFFFFF, 1'b0, 1'b1};
        tbl[12] = '{64'hC1E0000000100000, RTZ, 32'h80000000, 1'b0, 1'b1};
        tbl[13] = '{64'hC1E0000000100000, RDN, 32'h80000000, 1'b1, 1'b0};
        tbl[14] = '{64'h41DFFFFFFFE00000, RNE, 32'h7FFFFFFF, 1'b1, 1'b0};
        tbl[15] = '{64'h41DFFFFFFFE00000, RTZ, 32'h7FFFFFFF, 1'b0, 1'b1};
        tbl[16] = '{64'hBFE0000000000000, RNE, 32'h00000000, 1'b0, 1'b1};
        tbl[17] = '{64'h3FE0000000000000, RUP, 32'h00000001, 1'b0, 1'b1};
        tbl[18] = '{64'h7E37E43C8800759C, RTZ, 32'h7FFFFFFF, 1'b1, 1'b0};
        tbl[19] = '{64'hBFF0000000000000, RUP, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[20] = '{64'h4008000000000000, RDN, 32'h00000003, 1'b0, 1'b0};
        tbl[21] = '{64'h7FF0000000000000, RNE, 32'h7FFFFFFF, 1'b1, 1'b0};
        tbl[22] = '{64'h0000000000000001, RNE, 32'h00000000, 1'b0, 1'b1};
        tbl[23] = '{64'hC004000000000000, RNE, 32'hFFFFFFFE, 1'b0, 1'b1};
        tbl[24] = '{64'h400C000000000000, RNE, 32'h00000004, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; rm = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_invalid",   64'(invalid),   64'd0);
        check("rst_inexact",   64'(inexact),   64'd0);

        for (int i = 0; i < 25; i++) begin
            e = '{tbl[i].res, tbl[i].inv, tbl[i].inx};
            send(tbl[i].a, tbl[i].rm, e);
            if (i == 0) check("busy_in_ready", 64'(in_ready), 64'd0);
            collect($sformatf("vec%0d", i), 1'b1, edges);
            if (i == 0) check("latency_edges", 64'(edges), 64'd3);
        end

        // Backpressure: 7.25 RUP -> 8, held while out_ready is low
        out_ready = 1'b0;
        send(64'h401D000000000000, RUP, '{32'h00000008, 1'b0, 1'b1});
        collect("bp", 1'b0, edges);
        in_valid = 1'b1;
        a        = 64'h4000000000000000;
        rm       = RNE;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_result", k),    64'(result),    64'(last_exp.res));
            check($sformatf("bp_hold%0d_flags", k),     64'({invalid, inexact}), 64'({last_exp.inv, last_exp.inx}));
            check($sformatf("bp_hold%0d_in_ready", k),  64'(in_ready),  64'd0);
            check($sformatf("bp_hold%0d_out_valid", k), 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  64'(in_ready),  64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        watch_no_output("bp_no_second_accept", 6);

        // Reset during ALIGN
        drive(64'h4024000000000000, RNE);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_align_in_ready",  64'(in_ready),  64'd1);
        check("rst_align_out_valid", 64'(out_valid), 64'd0);
        watch_no_output("rst_align_no_output", 6);

        // Reset during ROUND
        drive(64'h4024000000000000, RNE);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_round_in_ready",  64'(in_ready),  64'd1);
        check("rst_round_out_valid", 64'(out_valid), 64'd0);
        watch_no_output("rst_round_no_output", 6);

        // -10.5 RNE -> -10 after the aborted conversions
        send(64'hC025000000000000, RNE, '{32'hFFFFFFF6, 1'b0, 1'b1});
        collect("post_rst", 1'b1, edges);

        for (int i = 0; i < 100; i++) begin
            int  sv;
            real r;
            sv = int'($urandom);
            if (i == 0) sv = 32'sh7FFFFFFF;
            if (i == 1) sv = 32'sh80000000;
            if (i == 2) sv = 0;
            r = real'(sv);
            send($realtobits(r), RTZ, '{32'(sv), 1'b0, 1'b0});
            collect($sformatf("rand%0d", i), 1'b1, edges);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
